// File: rtl/coffee_bus_pkg.sv
// Shared CPU-bus constants for the character RAM write side: region decode,
// control register addresses, fill command field positions and fill FSM states.
package coffee_bus_pkg;

    localparam logic [3:0]  CHAR_REGION   = 4'hE;
    localparam logic [15:0] BASE_REG_ADDR = 16'hFFFD;
    localparam logic [15:0] CMD_REG_ADDR  = 16'hFFFE;

    localparam int unsigned START_BIT = 31;
    localparam int unsigned ABORT_BIT = 30;
    localparam int unsigned LEN_LSB   = 8;
    localparam int unsigned LEN_MSB   = 19;

    // Command length field is length-1; the counter needs one extra bit for 4096
    localparam int unsigned LEN_W = LEN_MSB - LEN_LSB + 1;
    localparam int unsigned CNT_W = LEN_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } fill_state_e;

endpackage

// File: rtl/charram_fill_engine.sv
// Fill engine: walks a pointer from the latched base, writing one byte per
// unstalled cycle until the programmed length is exhausted or an abort arrives.
module charram_fill_engine
    import coffee_bus_pkg::*;
#(
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              stall_i,
    input  logic              base_we_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic              cmd_we_i,
    input  logic [7:0]        cmd_byte_i,
    input  logic [LEN_W-1:0]  cmd_len_i,
    input  logic              cmd_start_i,
    input  logic              cmd_abort_i,
    output logic              wr_req_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [7:0]        wr_data_o,
    output logic              busy_o,
    output logic              done_o
);

    fill_state_e       state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        byte_q, byte_d;
    logic              busy_q, done_q;
    logic              wr_req;
    logic              abort_cmd, start_cmd;

    // Abort wins over start when both are set in one command word
    assign abort_cmd = cmd_we_i && cmd_abort_i;
    assign start_cmd = cmd_we_i && cmd_start_i && !cmd_abort_i;

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        byte_d  = byte_q;
        wr_req  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (base_we_i) begin
                    base_d = base_i;
                end
                if (start_cmd) begin
                    state_d = FILL;
                    ptr_d   = base_q;
                    cnt_d   = CNT_W'(cmd_len_i) + CNT_W'(1);
                    byte_d  = cmd_byte_i;
                end
            end
            FILL: begin
                if (abort_cmd) begin
                    state_d = DONE;
                end else if (!stall_i) begin
                    wr_req = 1'b1;
                    ptr_d  = ptr_q + ADDR_W'(1);
                    cnt_d  = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (base_we_i) begin
                    base_d = base_i;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            base_q  <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            byte_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            byte_q  <= byte_d;
            busy_q  <= (state_d == FILL);
            done_q  <= (state_d == DONE);
        end
    end

    assign wr_req_o  = wr_req;
    assign wr_addr_o = ptr_q;
    assign wr_data_o = byte_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;

endmodule

// File: rtl/charram_arbiter.sv
// Char RAM write-port owner: decodes CPU stores and muxes CPU char writes
// (always first) with fill engine writes onto the single RAM write port.
module charram_arbiter #(
    parameter int unsigned ADDR_W        = 12,
    parameter logic [15:0] BASE_REG_ADDR = coffee_bus_pkg::BASE_REG_ADDR,
    parameter logic [15:0] CMD_REG_ADDR  = coffee_bus_pkg::CMD_REG_ADDR
) (
    input  logic              clock,
    input  logic              nRst,
    input  logic [15:0]       cpu_addr,
    input  logic [31:0]       cpu_data,
    input  logic              cpu_wren,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_data,
    output logic              ram_wren,
    output logic              busy,
    output logic              done
);

    logic              cpu_char, base_we, cmd_we;
    logic              eng_req;
    logic [ADDR_W-1:0] eng_addr;
    logic [7:0]        eng_data;
    logic              unused_cmd_bits;

    assign cpu_char = cpu_wren && (cpu_addr[15:12] == coffee_bus_pkg::CHAR_REGION);
    assign base_we  = cpu_wren && (cpu_addr == BASE_REG_ADDR);
    assign cmd_we   = cpu_wren && (cpu_addr == CMD_REG_ADDR);

    assign unused_cmd_bits = ^cpu_data[coffee_bus_pkg::ABORT_BIT-1:coffee_bus_pkg::LEN_MSB+1];

    charram_fill_engine #(
        .ADDR_W (ADDR_W)
    ) u_fill_engine (
        .clk_i       (clock),
        .rst_ni      (nRst),
        .stall_i     (cpu_char),
        .base_we_i   (base_we),
        .base_i      (cpu_data[ADDR_W-1:0]),
        .cmd_we_i    (cmd_we),
        .cmd_byte_i  (cpu_data[7:0]),
        .cmd_len_i   (cpu_data[coffee_bus_pkg::LEN_MSB:coffee_bus_pkg::LEN_LSB]),
        .cmd_start_i (cpu_data[coffee_bus_pkg::START_BIT]),
        .cmd_abort_i (cpu_data[coffee_bus_pkg::ABORT_BIT]),
        .wr_req_o    (eng_req),
        .wr_addr_o   (eng_addr),
        .wr_data_o   (eng_data),
        .busy_o      (busy),
        .done_o      (done)
    );

    // Zero-latency CPU path; the engine is stalled whenever this side is taken
    always_comb begin
        ram_addr = eng_addr;
        ram_data = eng_data;
        ram_wren = eng_req;
        if (cpu_char) begin
            ram_addr = cpu_addr[ADDR_W-1:0];
            ram_data = cpu_data[7:0];
            ram_wren = 1'b1;
        end
    end

endmodule
